time_set_ctrl: RTL
==================

// Module: time_set_ctrl
// PURPOSE
//  User time/date setting controller for the digital clock. Debounces sw_in[3:0] and runs an
//  edit-mode FSM over year/month/day/hour/minute/second with per-field wrap and month-length clamp.
//  Commits the edited values to watch_date as a one-cycle set_time pulse with packed bin_time.
//  Exports field_sel/blink so lcd_display_list can blink the field being edited.
// PARAMETERS
//  DB_CYCLES    500000  stable-level cycles before a switch change is accepted (10 ms @ 50 MHz)
//  TIMEOUT_SEC  30      en_1hz ticks with no key press in EDIT before abort without commit
//  YEAR_MAX     99      year field range 0..YEAR_MAX (20yy); year%4==0 is leap
// PORTS
//  clk        in   1   system clock
//  rst        in   1   reset, synchronous, active-low
//  en_1hz     in   1   one-cycle 1 Hz strobe from en_clk
//  sw_in      in   4   raw switches: [0] MODE, [1] NEXT, [2] UP, [3] DOWN; 1 = pressed
//  year       in   8   current year value from watch_date (binary)
//  month      in   8   current month, 1..12
//  day        in   8   current day, 1..31
//  hour       in   8   current hour, 0..23
//  minute     in   8   current minute, 0..59
//  second     in   8   current second, 0..59
//  set_time   out  1   one-cycle commit strobe to watch_date
//  bin_time   out  48  {year,month,day,hour,minute,second}, 8 bits each; edit registers
//  edit_mode  out  1   1 while in LOAD/EDIT
//  field_sel  out  3   field under edit: 0 yr,1 mon,2 day,3 hr,4 min,5 sec
//  blink      out  1   toggles on each en_1hz in EDIT; 0 outside EDIT
// BEHAVIOUR
//  - Reset (rst==0 at clk edge): state IDLE; set_time=0, edit_mode=0, field_sel=0, blink=0,
//    bin_time=0, debounce counters/levels=0, timeout counter=0. Reset mid-EDIT discards edits; no commit.
//  - Debounce: per switch, level accepted after DB_CYCLES consecutive equal samples; rising edge of
//    accepted level gives a one-cycle press pulse; press pulse latency DB_CYCLES+2 clk from raw edge.
//  - Press priority per cycle: MODE > NEXT > UP > DOWN; UP and DOWN pulsed together = both ignored.
//  - FSM states IDLE, LOAD, EDIT, COMMIT:
//    IDLE  : MODE -> LOAD. Other presses ignored.
//    LOAD  : one cycle; capture year..second inputs into edit regs; field_sel=0 -> EDIT.
//    EDIT  : NEXT: field_sel 0..5, 5 wraps to 0. UP/DOWN: inc/dec selected field, wrap:
//            year 0..YEAR_MAX, month 1..12, day 1..dim, hour 0..23, minute/second 0..59.
//            MODE -> COMMIT. Timeout counter cleared on any press, +1 on en_1hz;
//            reaching TIMEOUT_SEC -> IDLE, no set_time.
//    COMMIT: set_time=1 for exactly this cycle, bin_time holds edit regs -> IDLE next cycle.
//  - dim (days in month): 31 for 1,3,5,7,8,10,12; 30 for 4,6,9,11; Feb 29 if year%4==0 else 28.
//  - Clamp: after any month/year change, day>dim forces day=dim in the same update cycle.
//  - bin_time stable from LOAD until next LOAD; edit regs change only in EDIT, one cycle after press.
//  - All arithmetic 8-bit unsigned; decrement at field minimum wraps to field maximum, never underflows.
//  - blink reset to 1 on entry to EDIT and on every press so the field is visible while adjusting.
// STRUCTURE
//  - clock_pkg: field index localparams (FLD_YEAR..FLD_SEC), state encoding, field min/max
//    constants, days-in-month function (month, leap) shared with watch_date.
//  - Sub-module sw_debounce (DB_CYCLES param; clk, rst, raw, level, press), instanced 4x via generate.
//  - Controller: FSM, edit regs, inc/dec/wrap/clamp datapath, timeout counter, blink toggle.
// TESTING (sim with DB_CYCLES=4, TIMEOUT_SEC=3)
//  - Debounce: 3-cycle glitch on UP -> no press; 6-cycle hold -> exactly one press pulse, DB_CYCLES+2 late.
//  - Enter/commit: inputs 24/3/15/10/20/30, MODE, MODE -> set_time high 1 cycle,
//    bin_time=0x18030F0A141E; edit_mode 0 after.
//  - Wrap: field 3 at 23, UP -> 0; field 4 at 0, DOWN -> 59; NEXT x6 from 0 -> field_sel=0.
//  - Clamp: year 23, month 3, day 31, field 1 DOWN -> month 2, day 28; year 24 -> day 29.
//  - Timeout: EDIT, no keys, 3 en_1hz -> IDLE, set_time never asserted; UP+DOWN together -> no change.
//  - Reset mid-EDIT after UP presses: rst low 1 cycle -> all outputs at reset values, no set_time.

Source files
------------

// File: rtl/time_set_ctrl_pkg.sv
// Shared definitions for the time/date setting controller: field indices,
// FSM state encoding, per-field range limits and calendar helpers.
package time_set_ctrl_pkg;

  // Field index as exported on field_sel
  localparam logic [2:0] FLD_YEAR  = 3'd0;
  localparam logic [2:0] FLD_MONTH = 3'd1;
  localparam logic [2:0] FLD_DAY   = 3'd2;
  localparam logic [2:0] FLD_HOUR  = 3'd3;
  localparam logic [2:0] FLD_MIN   = 3'd4;
  localparam logic [2:0] FLD_SEC   = 3'd5;

  // Field limits (year maximum is a module parameter, this is its default)
  localparam int         DEF_YEAR_MAX = 99;
  localparam logic [7:0] YEAR_MIN     = 8'd0;
  localparam logic [7:0] MONTH_MIN    = 8'd1;
  localparam logic [7:0] MONTH_MAX    = 8'd12;
  localparam logic [7:0] DAY_MIN      = 8'd1;
  localparam logic [7:0] HOUR_MIN     = 8'd0;
  localparam logic [7:0] HOUR_MAX     = 8'd23;
  localparam logic [7:0] MS_MIN       = 8'd0;
  localparam logic [7:0] MS_MAX       = 8'd59;

  // Edit-mode controller states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EDIT   = 2'd2,
    ST_COMMIT = 2'd3
  } state_t;

  // Switch bit positions on sw_in
  localparam int SW_MODE = 0;
  localparam int SW_NEXT = 1;
  localparam int SW_UP   = 2;
  localparam int SW_DOWN = 3;

  // Years 20yy with yy%4==0 are leap years within the 2000..2099 window
  function automatic logic is_leap(input logic [7:0] year);
    return (year[1:0] == 2'b00);
  endfunction

  // Days in a month; out-of-range months fall back to 31
  function automatic logic [7:0] days_in_month(input logic [7:0] month, input logic leap);
    logic [7:0] d;
    case (month)
      8'd2:                    d = leap ? 8'd29 : 8'd28;
      8'd4, 8'd6, 8'd9, 8'd11: d = 8'd30;
      default:                 d = 8'd31;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/time_set_ctrl_sw_debounce.sv
// Single-switch debouncer: a level is accepted after DB_CYCLES consecutive
// samples that differ from the current accepted level, and a rising edge of
// the accepted level yields a one-cycle press pulse.
module sw_debounce #(
  parameter int DB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int             CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DB_CYCLES - 1);

  logic          r_sync;
  logic          r_level;
  logic          r_level_d;
  logic          r_press;
  logic [CW-1:0] r_cnt;

  // Sample the raw switch, count stable differing samples, flip the level, edge-detect
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_sync    <= 1'b0;
      r_level   <= 1'b0;
      r_level_d <= 1'b0;
      r_press   <= 1'b0;
      r_cnt     <= '0;
    end else begin
      r_sync    <= raw;
      r_level_d <= r_level;
      r_press   <= r_level & ~r_level_d;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= r_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign level = r_level;
  assign press = r_press;

endmodule

// File: rtl/time_set_ctrl.sv
// Time/date setting controller: debounced MODE/NEXT/UP/DOWN keys drive an
// IDLE/LOAD/EDIT/COMMIT editor over year..second with per-field wrap and a
// month-length clamp on the day. Commits as a one-cycle set_time strobe.
// Key pulses are single-cycle strobes from the debouncers; the FSM acts on a
// pulse in the cycle it is high and never needs to hold off a source.
module time_set_ctrl
  import time_set_ctrl_pkg::*;
#(
  parameter int DB_CYCLES   = 500000,
  parameter int TIMEOUT_SEC = 30,
  parameter int YEAR_MAX    = DEF_YEAR_MAX
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_1hz,
  input  logic [3:0]  sw_in,
  input  logic [7:0]  year,
  input  logic [7:0]  month,
  input  logic [7:0]  day,
  input  logic [7:0]  hour,
  input  logic [7:0]  minute,
  input  logic [7:0]  second,
  output logic        set_time,
  output logic [47:0] bin_time,
  output logic        edit_mode,
  output logic [2:0]  field_sel,
  output logic        blink,
  output logic [1:0]  o_dbg_state,
  output logic [3:0]  o_dbg_sw_level
);

  localparam int             TW       = (TIMEOUT_SEC > 1) ? $clog2(TIMEOUT_SEC + 1) : 1;
  localparam logic [TW-1:0]  TO_LAST  = TW'(TIMEOUT_SEC - 1);
  localparam logic [7:0]     YEAR_TOP = 8'(YEAR_MAX);

  logic [3:0] w_level;
  logic [3:0] w_press;

  // One debouncer per switch
  for (genvar gi = 0; gi < 4; gi++) begin : g_db
    sw_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk   (clk),
      .rst   (rst),
      .raw   (sw_in[gi]),
      .level (w_level[gi]),
      .press (w_press[gi])
    );
  end

  // Priority decode: MODE > NEXT > UP > DOWN; UP with DOWN cancels both
  logic w_p_mode, w_p_next, w_p_up, w_p_down, w_p_edit;
  always_comb begin
    w_p_mode = w_press[SW_MODE];
    w_p_next = w_press[SW_NEXT] & ~w_press[SW_MODE];
    w_p_up   = w_press[SW_UP]   & ~w_press[SW_DOWN] & ~w_press[SW_MODE] & ~w_press[SW_NEXT];
    w_p_down = w_press[SW_DOWN] & ~w_press[SW_UP]   & ~w_press[SW_MODE] & ~w_press[SW_NEXT];
    w_p_edit = w_p_next | w_p_up | w_p_down;
  end

  state_t        r_state;
  logic [7:0]    r_yr, r_mo, r_dy, r_hr, r_mi, r_se;
  logic [TW-1:0] r_tcnt;

  logic [7:0] w_cur, w_lo, w_hi, w_res, w_dim;
  logic [7:0] w_nyr, w_nmo, w_ndy, w_nhr, w_nmi, w_nse;

  // Next value of the edit registers for an UP/DOWN on the selected field, day clamped
  always_comb begin
    w_nyr = r_yr;
    w_nmo = r_mo;
    w_ndy = r_dy;
    w_nhr = r_hr;
    w_nmi = r_mi;
    w_nse = r_se;
    w_cur = 8'd0;
    w_lo  = 8'd0;
    w_hi  = 8'd0;
    case (field_sel)
      FLD_YEAR:  begin w_cur = r_yr; w_lo = YEAR_MIN;  w_hi = YEAR_TOP;  end
      FLD_MONTH: begin w_cur = r_mo; w_lo = MONTH_MIN; w_hi = MONTH_MAX; end
      FLD_DAY:   begin w_cur = r_dy; w_lo = DAY_MIN;   w_hi = days_in_month(r_mo, is_leap(r_yr)); end
      FLD_HOUR:  begin w_cur = r_hr; w_lo = HOUR_MIN;  w_hi = HOUR_MAX;  end
      FLD_MIN:   begin w_cur = r_mi; w_lo = MS_MIN;    w_hi = MS_MAX;    end
      default:   begin w_cur = r_se; w_lo = MS_MIN;    w_hi = MS_MAX;    end
    endcase
    // Compare with >= / <= so out-of-range loaded values still wrap into range
    if (w_p_up) begin
      w_res = (w_cur >= w_hi) ? w_lo : w_cur + 8'd1;
    end else begin
      w_res = (w_cur <= w_lo) ? w_hi : w_cur - 8'd1;
    end
    case (field_sel)
      FLD_YEAR:  w_nyr = w_res;
      FLD_MONTH: w_nmo = w_res;
      FLD_DAY:   w_ndy = w_res;
      FLD_HOUR:  w_nhr = w_res;
      FLD_MIN:   w_nmi = w_res;
      default:   w_nse = w_res;
    endcase
    w_dim = days_in_month(w_nmo, is_leap(w_nyr));
    if ((field_sel == FLD_YEAR || field_sel == FLD_MONTH) && (w_ndy > w_dim)) begin
      w_ndy = w_dim;
    end
  end

  // Edit-mode FSM with registered outputs, edit registers, timeout and blink
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= ST_IDLE;
      set_time  <= 1'b0;
      edit_mode <= 1'b0;
      field_sel <= FLD_YEAR;
      blink     <= 1'b0;
      r_tcnt    <= '0;
      r_yr      <= 8'd0;
      r_mo      <= 8'd0;
      r_dy      <= 8'd0;
      r_hr      <= 8'd0;
      r_mi      <= 8'd0;
      r_se      <= 8'd0;
    end else begin
      set_time <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_p_mode) begin
            r_state   <= ST_LOAD;
            edit_mode <= 1'b1;
          end
        end
        ST_LOAD: begin
          r_yr      <= year;
          r_mo      <= month;
          r_dy      <= day;
          r_hr      <= hour;
          r_mi      <= minute;
          r_se      <= second;
          field_sel <= FLD_YEAR;
          blink     <= 1'b1;
          r_tcnt    <= '0;
          r_state   <= ST_EDIT;
        end
        ST_EDIT: begin
          if (w_p_mode) begin
            r_state   <= ST_COMMIT;
            set_time  <= 1'b1;
            edit_mode <= 1'b0;
            blink     <= 1'b0;
          end else if (w_p_edit) begin
            r_tcnt <= '0;
            blink  <= 1'b1;
            if (w_p_next) begin
              field_sel <= (field_sel == FLD_SEC) ? FLD_YEAR : field_sel + 3'd1;
            end else begin
              r_yr <= w_nyr;
              r_mo <= w_nmo;
              r_dy <= w_ndy;
              r_hr <= w_nhr;
              r_mi <= w_nmi;
              r_se <= w_nse;
            end
          end else if (en_1hz) begin
            if (r_tcnt >= TO_LAST) begin
              r_state   <= ST_IDLE;
              edit_mode <= 1'b0;
              blink     <= 1'b0;
              r_tcnt    <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
              blink  <= ~blink;
            end
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bin_time       = {r_yr, r_mo, r_dy, r_hr, r_mi, r_se};
  assign o_dbg_state    = r_state;
  assign o_dbg_sw_level = w_level;

endmodule
